// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of the UART transmitter. Write strobes are spaced one
// full frame apart because the transmitter cannot report that it is busy.
module uart_tx_queue #(
    parameter int FREQ  = 27000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [7:0]               data_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic                     write_o,
    output logic [7:0]               val_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     idle_o
);

    localparam int BIT_CNT = FREQ / BAUD;
    localparam int GAP     = 11 * BIT_CNT;
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int CW      = $clog2(GAP);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic [0:0]    state;
    logic [CW-1:0] gap_cnt;
    logic          push;
    logic          pop;
    logic          slot_free;

    assign ready_o = (level != LW'(DEPTH));
    assign push    = valid_i && ready_o;
    // The final WAIT cycle (counter at zero) may already issue the next strobe,
    // which keeps back-to-back strobes exactly GAP cycles apart.
    assign slot_free = (state == S_IDLE) || (gap_cnt == '0);
    assign pop       = slot_free && (level != '0) && !flush_i;

    assign level_o = level;
    assign idle_o  = (level == '0) && (state == S_IDLE) && !write_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
            write_o <= 1'b0;
            val_o   <= 8'h00;
        end else begin
            write_o <= 1'b0;
            if (pop) begin
                write_o <= 1'b1;
                val_o   <= mem[rd_ptr];
                gap_cnt <= CW'(GAP - 1);
                state   <= S_WAIT;
            end else if (slot_free) begin
                state <= S_IDLE;
            end else begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Buffered front-end for the UART transmitter; sits directly upstream of it.
- Accepts bytes from the CPU/bus side through a valid/ready handshake and holds them in a FIFO.
- Issues single-cycle write strobes with a data byte to the transmitter. Strobes are paced so that no strobe arrives before the transmitter's previous 11-bit frame has fully shifted out.
- The transmitter has no busy flag, so this block owns all frame timing.

Parameters:
- FREQ, 27000000, clock frequency in Hz.
- BAUD, 115200, line rate.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- Derived: BIT_CNT = FREQ/BAUD (integer division); GAP = 11*BIT_CNT cycles.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  upstream byte valid.
- data_i  in  8  upstream byte.
- ready_o  out  1  FIFO can accept a byte.
- flush_i  in  1  synchronous clear of FIFO contents.
- write_o  out  1  one-cycle strobe to the transmitter's write input.
- val_o  out  8  byte for the transmitter, valid while write_o=1.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- idle_o  out  1  FIFO empty and pacer in IDLE.

Behaviour:
- Reset (async assert, sync use): level_o=0, write_o=0, val_o=8'h00, pacer state IDLE, gap counter 0. ready_o=1 and idle_o=1 from the first cycle after reset.
- Push: occurs when valid_i && ready_o at a clock edge.
  - ready_o = (level != DEPTH), computed only from registered occupancy.
  - A push is refused while full, even if a pop happens the same cycle.
- FIFO storage:
  - Circular buffer with read/write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - Occupancy is kept as a separate counter of width $clog2(DEPTH)+1.
  - Push and pop in the same cycle leave the level unchanged.
- Pacer FSM has two states, IDLE and WAIT.
  - IDLE, FIFO non-empty:
    - next edge sets write_o=1 and val_o=head entry;
    - pops the head;
    - loads the gap counter with GAP-1;
    - moves to WAIT.
  - WAIT:
    - write_o=0; val_o holds its last value;
    - the counter decrements each cycle;
    - when the counter is 0 and the cycle completes, return to IDLE.
    - Result: the next strobe comes exactly GAP cycles after the previous one if data is waiting.
  - GAP is sized so that the worst-case first-bit phase of the transmitter's free-running bit counter (up to BIT_CNT cycles) plus 10 further bit periods completes before the next write.
- Latency:
  - A byte pushed into an empty FIFO with the pacer in IDLE appears on write_o two edges after the push edge: the push edge, then the strobe edge.
  - The pop uses registered occupancy, so the FIFO must be non-empty before the strobe edge.
- flush_i:
  - Synchronous: zeroes level and both pointers; takes priority over a same-cycle push and pop.
  - Does not abort WAIT; the gap in progress completes.
  - A strobe already asserted that cycle is not retracted.
- idle_o = (level==0) && state==IDLE && !write_o.
- Reset asserted mid-WAIT or mid-fill drops all contents immediately. The transmitter is reset by its own reset.
- No overflow or underflow is possible by construction. Pops happen only when level>0; pushes only when ready_o=1.

Test Plan:
- Common setup: FREQ=1152000, BAUD=115200, so BIT_CNT=10 and GAP=110; DEPTH=4.
- Single byte: reset, push 8'hA5 at edge t -> write_o=1 with val_o=8'hA5 at edge t+1, high for exactly one cycle; idle_o=1 again 110 cycles after the strobe.
- Back-to-back: push 8'h11, 8'h22, 8'h33 on consecutive cycles -> strobes at t+1, t+111, t+221 with val_o=11, 22, 33 in order; level_o peaks at 2.
- Full: push 6 bytes continuously -> 1 is popped immediately; ready_o=0 once level_o=4; the extra byte is held by upstream and accepted only on the cycle after the next pop; all 6 bytes are emitted in order, 110 cycles apart.
- Wrap-around: stream 10 bytes 0x00..0x09 through DEPTH=4 -> output order is exact; level_o never exceeds 4.
- flush_i pulse with 3 bytes queued mid-WAIT -> level_o=0 next cycle; no further strobes; idle_o=1 after the current gap expires.
- Async reset asserted mid-WAIT with 2 bytes queued -> write_o=0 and level_o=0 immediately, without a clock edge; a new push after release strobes at t+1.
